fetch_dispatch: RTL
===================

# fetch_dispatch

Instruction fetch/decode/dispatch sequencer for the microcontroller. It fetches one 16-bit word per instruction from synchronous program memory and splits it into opcode and two 6-bit operands. It hands the instruction to the matching execution FSM (MOV, ADD, …) with a level `start` and waits for that unit's `done`, then pulses `donefetch` to return the unit to its idle state. JMP and HALT are handled locally; illegal opcodes and hung units are flagged.

## Interface
- `PC_W`, 8: program counter / memory address width.
- `NUM_UNITS`, 4: number of execution FSMs. Opcodes `0..NUM_UNITS-1` dispatch to them; `NUM_UNITS` must be ≤ 14.
- `TIMEOUT`, 64: maximum EXEC cycles before the watchdog fires; ≥ 2.

Ports:
- `clk`  in  1  system clock; all state on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `run`  in  1  leave IDLE and begin fetching.
- `mem_addr`  out  PC_W  program memory address. Equals `pc`.
- `mem_rd`  out  1  read strobe. Memory returns data on the next cycle.
- `mem_data`  in  16  instruction word. `[15:12]` opcode, `[11:6]` parameter1, `[5:0]` parameter2.
- `parameter1`, `parameter2`  out  6  operands to execution units.
- `start`  out  NUM_UNITS  one-hot level start, one bit per unit.
- `done`  in  NUM_UNITS  per-unit completion flags.
- `donefetch`  out  1  one-cycle completion pulse. Resets all execution FSMs.
- `pc`  out  PC_W  current program counter.
- `halted`  out  1  HALT executed.
- `err`  out  1  sticky: illegal opcode or watchdog timeout.

## Operation
- States: IDLE, FETCH, LOAD, DECODE, EXEC, DONE, HALT.
- IDLE: all strobes low. Go to FETCH when `run` = 1.
- FETCH: `mem_rd` = 1. Go to LOAD.
- LOAD: `ir <= mem_data`. Go to DECODE.
- DECODE: take `op = ir[15:12]`.
  - If `op < NUM_UNITS`: go to EXEC.
  - If `op = 4'hE` (JMP): set the jump flag and go to DONE. The target is `ir[PC_W-1:0]`.
  - If `op = 4'hF`: go to HALT.
  - Otherwise: set `err` and go to DONE.
- EXEC: `start[op]` = 1, all other `start` bits 0. Watchdog counts from 0.
  - If `done[op]` = 1: go to DONE.
  - Else if the watchdog reaches `TIMEOUT-1`: set `err` and go to DONE.
  - `done` bits of other units are ignored.
- DONE: `donefetch` = 1 and `start` = 0. `pc <= jump ? target : pc+1`. Clear the jump flag. Go to FETCH.
- HALT: `halted` = 1 and no memory reads. Only reset leaves this state.
- `pc` increments modulo 2^PC_W, so `{PC_W{1}}` wraps to 0.
- `parameter1` and `parameter2` are driven from `ir` continuously. They are stable from DECODE through DONE.
- `run` is sampled only in IDLE. Deasserting it later has no effect.
- `err` clears only on reset.

## Timing
- Reset (`rst` = 0, any state, including mid-EXEC) takes effect immediately:
  - State IDLE; `pc`, `ir`, and the watchdog = 0.
  - `mem_rd`, `start`, `donefetch`, `halted`, `err`, `parameter1`, `parameter2` = 0.
- The fetch sequence, relative to FETCH at cycle n:
  - `mem_data` is sampled at the end of cycle n+1.
  - Decode happens at n+2.
  - EXEC begins at n+3 with `start[op]` high.
- If `done[op]` is first high in cycle n+k (k ≥ 3):
  - `start[op]` falls and `donefetch` is high in cycle n+k+1.
  - The new `pc` is visible and the next FETCH occurs at n+k+2.
  - A unit that asserts `done` in its 3rd start cycle gives a 7-cycle instruction.
- JMP and illegal opcodes: DONE at n+3, next FETCH at n+4.
- `done` already high on the first EXEC cycle is accepted: one cycle of `start`.
- `done` and the watchdog limit in the same cycle: `done` wins and `err` is not set.
- Exactly one `donefetch` pulse per non-HALT instruction. `start` and `donefetch` are never high together.

## Test plan
- Reset: hold `rst` = 0 and toggle `run` and `done` → all outputs 0. After release with `run` = 0, `mem_rd` stays 0.
- MOV R1,R2: word 16'h0042 at address 0, `run` pulse, `done[0]` high in the 3rd start cycle.
  - `parameter1` = 1, `parameter2` = 2; `start` = 4'b0001 for 3 cycles.
  - `donefetch` for 1 cycle, then `pc` = 1 and `mem_rd` with `mem_addr` = 1.
- JMP: 16'hE0A5 → no `start`; one `donefetch`; `pc` = 8'hA5. The next fetch reads 0xA5.
- HALT: 16'hF000 → `halted` = 1, no `donefetch`, `mem_rd` stays 0 for 20 cycles. A `rst` pulse returns to IDLE.
- Illegal opcode 4'h7 and watchdog:
  - Opcode 4'h7 with `NUM_UNITS` = 4 → `err` = 1, `pc` advances.
  - A unit that never asserts `done` → `start` held exactly `TIMEOUT` cycles, `err` = 1, `donefetch` pulses.
- PC wrap and reset mid-EXEC:
  - Instruction at 8'hFF completes → `pc` = 0.
  - `rst` low during EXEC → `start` drops within the same cycle, `pc` = 0.

Source files
------------

// File: rtl/fetch_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : fetch_dispatch
// Description : Instruction fetch / decode / dispatch sequencer. Fetches one
//               16-bit word per instruction from synchronous program memory,
//               splits it into opcode and two 6-bit operands, and hands it to
//               the matching execution unit with a level start. When that
//               unit reports done, a one-cycle donefetch pulse returns the
//               unit to idle. JMP and HALT are handled locally. Illegal
//               opcodes and hung units set a sticky error flag.
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous reset, active low
//               run        - leave IDLE and begin fetching
//               mem_addr   - program memory address (equals pc)
//               mem_rd     - read strobe, data returns on the next cycle
//               mem_data   - instruction word {op[3:0], p1[5:0], p2[5:0]}
//               parameter1 - operand 1 to execution units
//               parameter2 - operand 2 to execution units
//               start      - one-hot level start, one bit per unit
//               done       - per-unit completion flags
//               donefetch  - one-cycle completion pulse, resets the units
//               pc         - current program counter
//               halted     - HALT executed
//               err        - sticky illegal-opcode / watchdog flag
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_dispatch #(
  parameter int PC_W      = 8,
  parameter int NUM_UNITS = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  output logic [PC_W-1:0]      mem_addr,
  output logic                 mem_rd,
  input  logic [15:0]          mem_data,
  output logic [5:0]           parameter1,
  output logic [5:0]           parameter2,
  output logic [NUM_UNITS-1:0] start,
  input  logic [NUM_UNITS-1:0] done,
  output logic                 donefetch,
  output logic [PC_W-1:0]      pc,
  output logic                 halted,
  output logic                 err
);

  localparam int              WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [3:0]      OP_JMP  = 4'hE;
  localparam logic [3:0]      OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_DONE   = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic [15:0]            ir;
  logic                   jump;
  logic [WD_W-1:0]        wd;
  logic [3:0]             op;
  logic [NUM_UNITS-1:0]   unit_sel;
  logic                   op_is_unit;
  logic                   done_hit;
  logic                   err_set;

  assign op         = ir[15:12];
  assign parameter1 = ir[11:6];
  assign parameter2 = ir[5:0];
  assign mem_addr   = pc;

  // One-hot unit select straight from the opcode; all-zero for JMP, HALT
  // and illegal opcodes, which keeps done bits of other units out of play.
  always_comb begin
    unit_sel = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      unit_sel[i] = (op == 4'(i));
    end
  end

  assign op_is_unit = |unit_sel;
  assign done_hit   = |(done & unit_sel);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    mem_rd     = 1'b0;
    start      = '0;
    donefetch  = 1'b0;
    halted     = 1'b0;
    err_set    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (run) next_state = S_FETCH;
      end
      S_FETCH: begin
        mem_rd     = 1'b1;
        next_state = S_LOAD;
      end
      S_LOAD: begin
        next_state = S_DECODE;
      end
      S_DECODE: begin
        if (op_is_unit) begin
          next_state = S_EXEC;
        end else if (op == OP_JMP) begin
          next_state = S_DONE;
        end else if (op == OP_HALT) begin
          next_state = S_HALT;
        end else begin
          err_set    = 1'b1;
          next_state = S_DONE;
        end
      end
      S_EXEC: begin
        start = unit_sel;
        // done is checked first so a completion on the watchdog's last
        // cycle is accepted without flagging an error.
        if (done_hit) begin
          next_state = S_DONE;
        end else if (wd == WD_LAST) begin
          err_set    = 1'b1;
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        donefetch  = 1'b1;
        next_state = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir   <= '0;
      pc   <= '0;
      jump <= 1'b0;
      wd   <= '0;
      err  <= 1'b0;
    end else begin
      if (state == S_LOAD) begin
        ir <= mem_data;
      end
      if (state == S_DECODE) begin
        wd   <= '0;
        jump <= (op == OP_JMP);
      end
      if (state == S_EXEC) begin
        wd <= wd + 1'b1;
      end
      if (state == S_DONE) begin
        pc   <= jump ? ir[PC_W-1:0] : pc + 1'b1;
        jump <= 1'b0;
      end
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
